// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding control for the 5-stage pipeline; controls are combinational, shadow updates next edge.
// Backpressure: mem_wait freezes the pipe, load-use inserts one bubble, taken branch flushes younger stages.
module pipe_hazard_unit #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_STAGES = 3,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic              id_is_mem,
    input  logic              branch_taken,
    input  logic              mem_ready,
    output logic              stall_pc,
    output logic              bubble_ex,
    output logic              freeze,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic [1:0]        fwd_rs1,
    output logic [1:0]        fwd_rs2,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              load;
        logic              mem;
    } stg_t;

    typedef struct packed {
        stg_t              base;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use1;
        logic              use2;
    } ex_t;

    localparam bit              FL_ID_EX  = (FLUSH_STAGES >= 2);
    localparam bit              FL_EX_MEM = (FLUSH_STAGES == 3);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_t              r_ex;
    stg_t             r_mem;
    stg_t             r_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    ex_t        w_id_ex;
    logic       w_mem_wait;
    logic       w_load_use;
    logic       w_branch;
    logic       w_lu_stall;
    logic       w_rs1_hit;
    logic       w_rs2_hit;
    logic [1:0] w_fwd1;
    logic [1:0] w_fwd2;

    // MEM result forwarding excludes loads: load-use already spaces the consumer by one bubble.
    function automatic logic [1:0] fwd_sel(
        input logic              use_x,
        input logic [REG_AW-1:0] rs,
        input stg_t              mem_e,
        input stg_t              wb_e
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (use_x && mem_e.v && mem_e.we && !mem_e.load &&
            (mem_e.rd != '0) && (mem_e.rd == rs)) begin
            sel = 2'd1;
        end else if (use_x && wb_e.v && wb_e.we &&
                     (wb_e.rd != '0) && (wb_e.rd == rs)) begin
            sel = 2'd2;
        end
        return sel;
    endfunction

    always_comb begin
        w_id_ex = '0;
        if (id_valid) begin
            w_id_ex.base.v    = 1'b1;
            w_id_ex.base.rd   = id_rd;
            w_id_ex.base.we   = id_we;
            w_id_ex.base.load = id_is_load;
            w_id_ex.base.mem  = id_is_mem;
            w_id_ex.rs1       = id_rs1;
            w_id_ex.rs2       = id_rs2;
            w_id_ex.use1      = id_use_rs1;
            w_id_ex.use2      = id_use_rs2;
        end
    end

    assign w_mem_wait = r_mem.v & r_mem.mem & ~mem_ready;
    assign w_rs1_hit  = id_use_rs1 & (id_rs1 == r_ex.base.rd);
    assign w_rs2_hit  = id_use_rs2 & (id_rs2 == r_ex.base.rd);
    assign w_load_use = id_valid & r_ex.base.v & r_ex.base.load &
                        (r_ex.base.rd != '0) & (w_rs1_hit | w_rs2_hit);

    // Priority: memory wait, then taken branch, then load-use.
    assign w_branch   = branch_taken & ~w_mem_wait;
    assign w_lu_stall = w_load_use & ~w_mem_wait & ~branch_taken;

    assign w_fwd1 = fwd_sel(r_ex.use1, r_ex.rs1, r_mem, r_wb);
    assign w_fwd2 = fwd_sel(r_ex.use2, r_ex.rs2, r_mem, r_wb);

    assign freeze       = ~rst & w_mem_wait;
    assign stall_pc     = ~rst & (w_mem_wait | w_lu_stall);
    assign bubble_ex    = ~rst & w_lu_stall;
    assign flush_if_id  = ~rst & w_branch;
    assign flush_id_ex  = ~rst & w_branch & FL_ID_EX;
    assign flush_ex_mem = ~rst & w_branch & FL_EX_MEM;
    assign fwd_rs1      = rst ? 2'd0 : w_fwd1;
    assign fwd_rs2      = rst ? 2'd0 : w_fwd2;
    assign stall_cycles = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (w_mem_wait) begin
            r_wb <= '0;
        end else if (w_branch) begin
            r_wb  <= r_mem;
            r_mem <= FL_EX_MEM ? stg_t'('0) : r_ex.base;
            r_ex  <= FL_ID_EX ? ex_t'('0) : w_id_ex;
        end else if (w_lu_stall) begin
            r_wb  <= r_mem;
            r_mem <= r_ex.base;
            r_ex  <= '0;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex.base;
            r_ex  <= w_id_ex;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((stall_pc | freeze) && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed vector bench for pipe_hazard_unit: four instances (flush depth 3/2/1, 4-bit counter) share one stimulus.
module tb_pipe_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_use_rs1, id_use_rs2, id_we, id_is_load, id_is_mem;
    logic       branch_taken, mem_ready;
    logic [4:0] id_rs1, id_rs2, id_rd;

    // instance index: 0 = FLUSH_STAGES 3, 1 = FLUSH_STAGES 2, 2 = FLUSH_STAGES 1, 3 = CNT_W 4
    logic        stall_pc [4];
    logic        bubble_ex [4];
    logic        freeze [4];
    logic        fl_if [4];
    logic        fl_id [4];
    logic        fl_ex [4];
    logic [1:0]  fwd1 [4];
    logic [1:0]  fwd2 [4];
    logic [31:0] cnt32 [3];
    logic [3:0]  cnt4;

    pipe_hazard_unit #(.FLUSH_STAGES(3)) u_fs3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .id_is_mem(id_is_mem), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .stall_pc(stall_pc[0]), .bubble_ex(bubble_ex[0]),
        .freeze(freeze[0]), .flush_if_id(fl_if[0]), .flush_id_ex(fl_id[0]),
        .flush_ex_mem(fl_ex[0]), .fwd_rs1(fwd1[0]), .fwd_rs2(fwd2[0]), .stall_cycles(cnt32[0]));

    pipe_hazard_unit #(.FLUSH_STAGES(2)) u_fs2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .id_is_mem(id_is_mem), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .stall_pc(stall_pc[1]), .bubble_ex(bubble_ex[1]),
        .freeze(freeze[1]), .flush_if_id(fl_if[1]), .flush_id_ex(fl_id[1]),
        .flush_ex_mem(fl_ex[1]), .fwd_rs1(fwd1[1]), .fwd_rs2(fwd2[1]), .stall_cycles(cnt32[1]));

    pipe_hazard_unit #(.FLUSH_STAGES(1)) u_fs1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .id_is_mem(id_is_mem), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .stall_pc(stall_pc[2]), .bubble_ex(bubble_ex[2]),
        .freeze(freeze[2]), .flush_if_id(fl_if[2]), .flush_id_ex(fl_id[2]),
        .flush_ex_mem(fl_ex[2]), .fwd_rs1(fwd1[2]), .fwd_rs2(fwd2[2]), .stall_cycles(cnt32[2]));

    pipe_hazard_unit #(.CNT_W(4)) u_c4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
        .id_is_load(id_is_load), .id_is_mem(id_is_mem), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .stall_pc(stall_pc[3]), .bubble_ex(bubble_ex[3]),
        .freeze(freeze[3]), .flush_if_id(fl_if[3]), .flush_id_ex(fl_id[3]),
        .flush_ex_mem(fl_ex[3]), .fwd_rs1(fwd1[3]), .fwd_rs2(fwd2[3]), .stall_cycles(cnt4));

    typedef struct {
        logic       rst, idv, u1, u2, we, ld, mem, br, mrdy;
        logic [4:0] rs1, rs2, rd;
        logic [5:0] ctl;   // {stall_pc, bubble_ex, freeze, flush_if_id, flush_id_ex, flush_ex_mem}
        logic [1:0] f1, f2;
        int         cnt;   // expected stall_cycles, -1 = unknown
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic row(input int r, v, rs1, u1, rs2, u2, rd, we, ld, mem, br, mrdy,
                       input logic [5:0] ctl, input int f1, f2, cnt);
        vec_t t;
        t.rst = r[0];   t.idv = v[0];   t.rs1 = rs1[4:0]; t.u1 = u1[0];
        t.rs2 = rs2[4:0]; t.u2 = u2[0]; t.rd = rd[4:0];   t.we = we[0];
        t.ld = ld[0];   t.mem = mem[0]; t.br = br[0];     t.mrdy = mrdy[0];
        t.ctl = ctl;    t.f1 = f1[1:0]; t.f2 = f2[1:0];   t.cnt = cnt;
        vq.push_back(t);
    endtask

    task automatic idle_row(input int mrdy, input logic [5:0] ctl, input int f1, f2, cnt);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mrdy, ctl, f1, f2, cnt);
    endtask

    task automatic apply(input vec_t t);
        rst = t.rst; id_valid = t.idv; id_rs1 = t.rs1; id_use_rs1 = t.u1;
        id_rs2 = t.rs2; id_use_rs2 = t.u2; id_rd = t.rd; id_we = t.we;
        id_is_load = t.ld; id_is_mem = t.mem; branch_taken = t.br; mem_ready = t.mrdy;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [9:0] outv(input int k);
        return {stall_pc[k], bubble_ex[k], freeze[k], fl_if[k], fl_id[k], fl_ex[k], fwd1[k], fwd2[k]};
    endfunction

    int n_wait;

    initial begin
        apply('{default: '0});

        // reset with arbitrary inputs
        row(1, 1, 3, 1, 4, 1, 9, 1, 1, 1, 1, 0, 6'b000000, 0, 0, -1);
        row(1, 1, 5, 1, 5, 1, 5, 1, 1, 1, 1, 1, 6'b000000, 0, 0, 0);
        idle_row(1, 6'b000000, 0, 0, 0);
        // ALU chain: x5, x6<-x5, x0<-x5, consumer of x0/x6, two writers of x10, consumer of x10
        row(0, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 0);
        row(0, 1, 5, 1, 3, 1, 6, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 0);
        row(0, 1, 5, 1, 4, 1, 0, 1, 0, 0, 0, 1, 6'b000000, 1, 0, 0);
        row(0, 1, 0, 1, 6, 1, 9, 1, 0, 0, 0, 1, 6'b000000, 2, 0, 0);
        row(0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 1, 6'b000000, 0, 2, 0);
        row(0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 0);
        row(0, 1, 10, 1, 9, 1, 11, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 0);
        idle_row(1, 6'b000000, 1, 0, 0);
        // load-use: ld x7 then consumer of rs2 = x7
        row(0, 1, 2, 1, 0, 0, 7, 1, 1, 1, 0, 1, 6'b000000, 0, 0, 0);
        row(0, 1, 1, 1, 7, 1, 12, 1, 0, 0, 0, 1, 6'b110000, 0, 0, 0);
        row(0, 1, 1, 1, 7, 1, 12, 1, 0, 0, 0, 1, 6'b000000, 0, 0, 1);
        idle_row(1, 6'b000000, 0, 2, 1);
        // memory wait: ld x13 stalls 3 cycles in MEM, branch held through the freeze
        row(0, 1, 1, 1, 0, 0, 13, 1, 1, 1, 0, 1, 6'b000000, 0, 0, 1);
        idle_row(1, 6'b000000, 0, 0, 1);
        idle_row(0, 6'b101000, 0, 0, 1);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b101000, 0, 0, 2);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b101000, 0, 0, 3);
        row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b000111, 0, 0, 4);
        row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 4);
        // branch in the same cycle as a load-use condition
        row(0, 1, 0, 0, 0, 0, 7, 1, 1, 1, 0, 1, 6'b000000, 0, 0, 0);
        row(0, 1, 7, 1, 0, 0, 12, 1, 0, 0, 1, 1, 6'b000111, 0, 0, 0);
        idle_row(1, 6'b000000, 0, 0, 0);
        row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0);
        // 20-cycle freeze: 32-bit counter reaches 20, 4-bit counter holds at 15
        row(0, 1, 0, 0, 0, 0, 7, 1, 1, 1, 0, 1, 6'b000000, 0, 0, 0);
        idle_row(1, 6'b000000, 0, 0, 0);
        for (int k = 0; k < 20; k++) idle_row(0, 6'b101000, 0, 0, k);
        idle_row(1, 6'b000000, 0, 0, 20);
        idle_row(1, 6'b000000, 0, 0, 20);

        for (int i = 0; i < vq.size(); i++) begin
            logic [5:0] ec;
            int         e4;
            @(negedge clk);
            apply(vq[i]);
            #1;
            for (int k = 0; k < 4; k++) begin
                ec = vq[i].ctl;
                if (k == 1) ec[0] = 1'b0;
                if (k == 2) ec[1:0] = 2'b00;
                chk($sformatf("outs_inst%0d", k), i, 32'(outv(k)), 32'({ec, vq[i].f1, vq[i].f2}));
            end
            if (vq[i].cnt >= 0) begin
                e4 = (vq[i].cnt > 15) ? 15 : vq[i].cnt;
                for (int k = 0; k < 3; k++)
                    chk($sformatf("stall_cycles_inst%0d", k), i, cnt32[k], 32'(vq[i].cnt));
                chk("stall_cycles_cnt4", i, 32'(cnt4), 32'(e4));
            end
        end

        // freeze of random length with a branch held until memory completes
        n_wait = $urandom_range(2, 6);
        @(negedge clk);
        apply('{rst: 1'b1, mrdy: 1'b1, default: '0});
        @(negedge clk);
        apply('{idv: 1'b1, rd: 5'd7, we: 1'b1, ld: 1'b1, mem: 1'b1, mrdy: 1'b1, default: '0});
        @(negedge clk);
        apply('{mrdy: 1'b1, default: '0});
        for (int i = 0; i < n_wait; i++) begin
            @(negedge clk);
            mem_ready    = 1'b0;
            branch_taken = 1'b1;
            #1;
            chk("held_branch_frozen", 100 + i, 32'(outv(0)), 32'({6'b101000, 4'b0}));
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("held_branch_release", 200, 32'(outv(0)), 32'({6'b000111, 4'b0}));
        chk("held_branch_count", 201, cnt32[0], 32'(n_wait));
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        chk("after_release_idle", 202, 32'(outv(0)), 32'd0);
        chk("after_release_count", 203, cnt32[0], 32'(n_wait));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard/forwarding controller for the 5-stage RV64 pipeline (IF, ID, EX, MEM, WB).
- Keeps its own shadow of the destination and source info for the EX, MEM and WB stages.
- From that shadow it generates:
  - load-use stalls;
  - memory-wait freezes;
  - configurable-depth branch flushes;
  - forwarding selects for the instruction in EX.
- Owns a saturating stall-cycle performance counter. The pipeline top instantiates it next to the stage modules.

Parameters:
- REG_AW, 5, register-index width.
- FLUSH_STAGES, 3, number of younger pipeline registers cleared on a taken branch (1 = IF/ID; 2 = +ID/EX; 3 = +EX/MEM). Legal values are 1..3.
- CNT_W, 32, width of the perf counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source registers of the ID instruction.
- id_use_rs1, id_use_rs2  in  1  the ID instruction reads that source.
- id_rd  in  REG_AW  destination of the ID instruction.
- id_we  in  1  the ID instruction writes rd.
- id_is_load  in  1  the ID instruction is a load.
- id_is_mem  in  1  the ID instruction is a load or store.
- branch_taken  in  1  taken branch resolved in MEM.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_pc  out  1  hold PC and IF/ID.
- bubble_ex  out  1  load ID/EX with a NOP.
- freeze  out  1  hold PC, IF/ID, ID/EX and EX/MEM; load MEM/WB with a NOP.
- flush_if_id, flush_id_ex, flush_ex_mem  out  1  clear that pipeline register.
- fwd_rs1, fwd_rs2  out  2  operand source for EX: 0 = regfile/ID_EX, 1 = EX/MEM result, 2 = MEM/WB write data.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Shadow entries:
  - EX entry = {v, rd, we, load, mem, rs1, rs2, use1, use2}.
  - MEM and WB entries = {v, rd, we, load, mem}.
  - A bubble is an entry with all fields 0.
- Reset: all entries become bubbles and stall_cycles = 0. Every output reads 0 in the cycle after rst is sampled high. rst overrides every other input.
- Hazards are never raised for register x0: matches on rd == 0 are ignored.
- mem_wait = MEM.v & MEM.mem & ~mem_ready.
- load_use = id_valid & EX.v & EX.load & EX.rd != 0, and either:
  - id_use_rs1 & id_rs1 == EX.rd, or
  - id_use_rs2 & id_rs2 == EX.rd.
- Output priority, all combinational from the current state and inputs:
  - 1) mem_wait: freeze = 1, stall_pc = 1. All flush, bubble and branch outputs stay 0, and branch_taken is ignored. The resolver holds branch_taken until it is accepted.
  - 2) branch_taken: flush_if_id = 1; flush_id_ex = (FLUSH_STAGES >= 2); flush_ex_mem = (FLUSH_STAGES == 3). load_use is suppressed.
  - 3) load_use: stall_pc = 1, bubble_ex = 1.
  - 4) Otherwise all control outputs are 0.
- Shadow update per case:
  - freeze: EX and MEM hold; WB <= bubble.
  - branch: WB <= MEM; MEM <= (FLUSH_STAGES == 3 ? bubble : EX); EX <= (FLUSH_STAGES >= 2 ? bubble : ID info gated by id_valid).
  - load_use: WB <= MEM; MEM <= EX; EX <= bubble.
  - normal: WB <= MEM; MEM <= EX; EX <= ID info gated by id_valid.
- Forwarding, combinational from the EX entry, evaluated per operand x:
  - fwd_rsx = 1 if EX.usex & MEM.v & MEM.we & ~MEM.load & MEM.rd != 0 & MEM.rd == EX.rsx.
  - Otherwise fwd_rsx = 2 if EX.usex & WB.v & WB.we & WB.rd != 0 & WB.rd == EX.rsx.
  - Otherwise fwd_rsx = 0.
  - MEM has priority over WB (youngest value wins).
  - A load in MEM never forwards: load-use guarantees one bubble between the load and its consumer.
- stall_cycles increments by 1 in each cycle where (stall_pc | freeze) and ~rst. It saturates at 2^CNT_W - 1.
- Latency:
  - Controls are valid in the same cycle as the causing inputs.
  - The shadow reflects a decision one cycle later.
  - A load-use stall lasts exactly 1 cycle.
  - A freeze lasts as long as mem_ready is low while the MEM entry is a memory op.

Test Plan:
- Reset: assert rst for 2 cycles with arbitrary inputs -> all outputs 0; stall_cycles = 0.
- ALU chain: add x5 then add x6 using x5 (rs1 = 5), back to back -> fwd_rs1 = 1 when the consumer is in EX; a third instruction using x5 two behind gets fwd_rs1 = 2; a consumer using x0 gets fwd = 0.
- Load-use:
  - ld x7, then ID uses rs2 = 7 -> stall_pc = bubble_ex = 1 for exactly 1 cycle.
  - The next cycle shows fwd_rs2 = 2 for the consumer in EX.
  - stall_cycles = 1.
- Memory wait:
  - ld reaches MEM with mem_ready = 0 for 3 cycles -> freeze = 1 for 3 cycles; stall_cycles increases by 3.
  - branch_taken asserted during the freeze yields no flush outputs until mem_ready = 1.
- Branch flush: branch_taken = 1 with FLUSH_STAGES = 3, 2 and 1 -> flush vectors {1,1,1}, {1,1,0} and {1,0,0}. Under the same cycle's load-use condition, bubble_ex = 0.
- Counter saturation: CNT_W = 4, 20 stalled cycles -> stall_cycles holds at 15.
